// File: rtl/popcount_pkg.sv
// Shared types and default widths for the popcount frame accumulator.
package popcount_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_ACCWIDTH  = 16;

endpackage

// File: rtl/popcount_frame_acc_sat_add.sv
// Unsigned adder that clips at all-ones and flags when clipping happened.
module sat_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        ovf = raw[WIDTH];
        sum = raw[WIDTH] ? '1 : raw[WIDTH-1:0];
    end

endmodule

// File: rtl/popcount_frame_acc.sv
// Accumulates per-word ones counts into frame totals and holds each result
// until the downstream consumer takes it.
module popcount_frame_acc
    import popcount_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int CNTWIDTH  = $clog2(DATAWIDTH) + 1,
    parameter int ACCWIDTH  = DEF_ACCWIDTH
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_Valid,
    input  logic [CNTWIDTH-1:0] i_Count,
    input  logic                i_Last,
    output logic                o_Ready,
    output logic                o_FrameValid,
    output logic [ACCWIDTH-1:0] o_FrameOnes,
    output logic [ACCWIDTH-1:0] o_FrameWords,
    output logic                o_Saturated,
    input  logic                i_FrameReady
);

    localparam logic [CNTWIDTH-1:0] MAX_CNT  = CNTWIDTH'(DATAWIDTH);
    localparam logic [ACCWIDTH-1:0] ONE_WORD = {{(ACCWIDTH-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [ACCWIDTH-1:0] frame_ones_q, frame_ones_d;
    logic [ACCWIDTH-1:0] frame_words_q, frame_words_d;
    logic                frame_sat_q, frame_sat_d;
    logic [ACCWIDTH-1:0] ones_acc_q, ones_acc_d;
    logic [ACCWIDTH-1:0] words_acc_q, words_acc_d;
    logic                sticky_q, sticky_d;

    logic [CNTWIDTH-1:0] count_clamped;
    logic [ACCWIDTH-1:0] count_ext;
    logic [ACCWIDTH-1:0] ones_sum;
    logic [ACCWIDTH-1:0] words_sum;
    logic                ones_ovf;
    logic                words_ovf;
    logic                accept;
    logic                sat_now;

    always_comb begin
        count_clamped = (i_Count > MAX_CNT) ? MAX_CNT : i_Count;
        count_ext     = ACCWIDTH'(count_clamped);
    end

    sat_add #(
        .WIDTH(ACCWIDTH)
    ) u_ones_add (
        .a   (ones_acc_q),
        .b   (count_ext),
        .sum (ones_sum),
        .ovf (ones_ovf)
    );

    sat_add #(
        .WIDTH(ACCWIDTH)
    ) u_words_add (
        .a   (words_acc_q),
        .b   (ONE_WORD),
        .sum (words_sum),
        .ovf (words_ovf)
    );

    assign accept  = i_Valid & ready_q;
    assign sat_now = sticky_q | ones_ovf | words_ovf;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        frame_ones_d  = frame_ones_q;
        frame_words_d = frame_words_q;
        frame_sat_d   = frame_sat_q;
        ones_acc_d    = ones_acc_q;
        words_acc_d   = words_acc_q;
        sticky_d      = sticky_q;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (i_Last) begin
                        // Final beat is folded straight into the published result.
                        frame_ones_d  = ones_sum;
                        frame_words_d = words_sum;
                        frame_sat_d   = sat_now;
                        valid_d       = 1'b1;
                        ones_acc_d    = '0;
                        words_acc_d   = '0;
                        sticky_d      = 1'b0;
                        state_d       = HOLD;
                    end else begin
                        ones_acc_d  = ones_sum;
                        words_acc_d = words_sum;
                        sticky_d    = sat_now;
                    end
                end
            end
            HOLD: begin
                if (i_FrameReady) begin
                    valid_d = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase

        ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ACCUM;
            ready_q       <= 1'b1;
            valid_q       <= 1'b0;
            frame_ones_q  <= '0;
            frame_words_q <= '0;
            frame_sat_q   <= 1'b0;
            ones_acc_q    <= '0;
            words_acc_q   <= '0;
            sticky_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            valid_q       <= valid_d;
            frame_ones_q  <= frame_ones_d;
            frame_words_q <= frame_words_d;
            frame_sat_q   <= frame_sat_d;
            ones_acc_q    <= ones_acc_d;
            words_acc_q   <= words_acc_d;
            sticky_q      <= sticky_d;
        end
    end

    assign o_Ready      = ready_q;
    assign o_FrameValid = valid_q;
    assign o_FrameOnes  = frame_ones_q;
    assign o_FrameWords = frame_words_q;
    assign o_Saturated  = frame_sat_q;

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Scoreboard bench for popcount_frame_acc at DATAWIDTH=16, ACCWIDTH=8.
module tb_popcount_frame_acc;

    localparam int DW   = 16;
    localparam int CW   = $clog2(DW) + 1;
    localparam int AW   = 8;
    localparam int AMAX = (1 << AW) - 1;

    typedef struct {
        int ones;
        int words;
        int sat;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [CW-1:0] count;
    logic          last;
    logic          ready;
    logic          fvalid;
    logic [AW-1:0] fones;
    logic [AW-1:0] fwords;
    logic          fsat;
    logic          fready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_cyc  = 0;

    frame_t exp_q[$];
    frame_t held;

    int m_ones  = 0;
    int m_words = 0;
    int m_sat   = 0;
    bit m_hold  = 1'b0;

    always #5 clk = ~clk;

    popcount_frame_acc #(
        .DATAWIDTH(DW),
        .ACCWIDTH (AW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_Valid     (valid),
        .i_Count     (count),
        .i_Last      (last),
        .o_Ready     (ready),
        .o_FrameValid(fvalid),
        .o_FrameOnes (fones),
        .o_FrameWords(fwords),
        .o_Saturated (fsat),
        .i_FrameReady(fready)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: first cycle of each presented result is matched to the scoreboard.
    bit prev_valid = 1'b0;
    always @(posedge clk) begin
        frame_t e;
        cyc++;
        #1;
        if (fvalid === 1'b1 && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("frame_ones", int'(fones), e.ones);
                chk("frame_words", int'(fwords), e.words);
                chk("frame_sat", int'(fsat), e.sat);
                chk("frame_latency", cyc, exp_cyc);
                held = e;
            end
        end
        prev_valid = (fvalid === 1'b1);
    end

    task automatic model_clear();
        m_ones  = 0;
        m_words = 0;
        m_sat   = 0;
    endtask

    // Drive one beat for one cycle; caller is positioned 1 time unit after an edge.
    task automatic beat(input int c, input bit l);
        int cl;
        chk("ready_at_beat", int'(ready), m_hold ? 0 : 1);
        valid = 1'b1;
        count = CW'(c);
        last  = l;
        if (!m_hold) begin
            cl = (c > DW) ? DW : c;
            m_ones += cl;
            if (m_ones > AMAX) begin m_ones = AMAX; m_sat = 1; end
            m_words += 1;
            if (m_words > AMAX) begin m_words = AMAX; m_sat = 1; end
            if (l) begin
                exp_q.push_back('{m_ones, m_words, m_sat});
                exp_cyc = cyc + 1;
                model_clear();
                m_hold = 1'b1;
            end
        end
        @(posedge clk); #1;
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic release_frame();
        fready = 1'b1;
        @(posedge clk); #1;
        fready = 1'b0;
        m_hold = 1'b0;
        chk("release_valid", int'(fvalid), 0);
        chk("release_ready", int'(ready), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        m_hold = 1'b0;
        exp_q.delete();
        chk("rst_ready", int'(ready), 1);
        chk("rst_valid", int'(fvalid), 0);
        chk("rst_ones", int'(fones), 0);
        chk("rst_words", int'(fwords), 0);
        chk("rst_sat", int'(fsat), 0);
    endtask

    initial begin
        rst    = 1'b1;
        valid  = 1'b0;
        count  = '0;
        last   = 1'b0;
        fready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Three-beat frame 13 + 1 + 10.
        beat(13, 0); beat(1, 0); beat(10, 1);
        drain();
        release_frame();

        // Single full-word beat.
        beat(16, 1);
        drain();

        // Backpressure: beats offered while the result is held are ignored.
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; count = CW'(15); last = 1'b1;
            @(posedge clk); #1;
            chk("bp_ready", int'(ready), 0);
            chk("bp_valid", int'(fvalid), 1);
            chk("bp_ones", int'(fones), held.ones);
            chk("bp_words", int'(fwords), held.words);
        end
        valid = 1'b0; last = 1'b0;
        release_frame();
        beat(3, 1);
        drain();
        release_frame();

        // Saturation of the ones accumulator, then a clean frame.
        for (int i = 0; i < 20; i++) beat(16, (i == 19));
        drain();
        release_frame();
        beat(5, 1);
        drain();
        release_frame();

        // Zero-count frame still produces a result.
        beat(0, 0); beat(0, 1);
        drain();
        release_frame();

        // Reset mid-frame discards the partial totals.
        beat(7, 0); beat(9, 0);
        do_reset();
        beat(4, 1);
        drain();
        release_frame();

        // Clamping of an over-range count.
        beat(31, 1);
        drain();
        release_frame();

        // Frame-ready in ACCUM must not disturb anything.
        fready = 1'b1;
        @(posedge clk); #1;
        fready = 1'b0;
        chk("idle_fready_ready", int'(ready), 1);
        chk("idle_fready_valid", int'(fvalid), 0);
        beat(2, 0); beat(6, 1);
        drain();
        release_frame();

        repeat (3) @(posedge clk);
        #1;
        chk("leftover_expected", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/popcount_frame_acc.md
POPCOUNT_FRAME_ACC -- requirements
Module: popcount_frame_acc

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16, giving the upstream word width in bits.
REQ-002 SHALL have parameter CNTWIDTH, default $clog2(DATAWIDTH)+1, giving the per-word ones-count width.
REQ-003 SHALL have parameter ACCWIDTH, default 16, giving the width of the frame total and word-count accumulators.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_Valid, input, 1 bit: an upstream ones-count beat is present.
REQ-007 SHALL have port i_Count, input, CNTWIDTH bits: ones count of one data word.
REQ-008 SHALL have port i_Last, input, 1 bit: the current beat is the final word of the frame.
REQ-009 SHALL have port o_Ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 SHALL have port o_FrameValid, output, 1 bit: a frame result is presented.
REQ-011 SHALL have port o_FrameOnes, output, ACCWIDTH bits: total ones in the frame.
REQ-012 SHALL have port o_FrameWords, output, ACCWIDTH bits: number of words in the frame.
REQ-013 SHALL have port o_Saturated, output, 1 bit: either frame accumulator clipped at its maximum.
REQ-014 SHALL have port i_FrameReady, input, 1 bit: the downstream consumer accepts the frame result.

Function
REQ-015 SHALL implement a two-state FSM: ACCUM and HOLD.
REQ-016 SHALL drive o_Ready as a registered function of state only: 1 in ACCUM, 0 in HOLD.
REQ-017 SHALL count a beat as accepted only when i_Valid=1 and o_Ready=1 on the same clock edge.
REQ-018 SHALL, when a beat is accepted in ACCUM, clamp i_Count to DATAWIDTH, add it to the ones accumulator, and add 1 to the word accumulator.
REQ-019 SHALL make both additions saturating at 2^ACCWIDTH-1; saturation of either accumulator sets a sticky saturation flag for the current frame.
REQ-020 SHALL, on an accepted beat with i_Last=1, include that beat in the totals and load o_FrameOnes, o_FrameWords and o_Saturated on the same edge.
REQ-021 SHALL, on that same edge, set o_FrameValid=1, clear the accumulators and the sticky flag, and move to HOLD.
REQ-022 SHALL present a frame result exactly 1 cycle after its last beat is accepted.
REQ-023 SHALL, in HOLD, keep o_FrameOnes, o_FrameWords and o_Saturated stable and ignore i_Valid, i_Count and i_Last.
REQ-024 SHALL, in HOLD, when i_FrameReady=1, clear o_FrameValid and return to ACCUM on the next edge; this gives a one-cycle bubble before the next beat can be accepted.
REQ-025 SHALL leave the state unchanged when i_FrameReady=1 arrives while o_FrameValid=0.
REQ-026 SHALL treat a single accepted beat with i_Last=1 as a complete one-word frame.
REQ-027 SHALL report a frame with all-zero counts as o_FrameOnes=0, with o_FrameValid asserted as normal.

Reset
REQ-028 SHALL, while i_rst=1 at a clock edge, set state=ACCUM, o_Ready=1, o_FrameValid=0, o_FrameOnes=0, o_FrameWords=0, o_Saturated=0, and clear both accumulators and the sticky flag.
REQ-029 SHALL, when reset is asserted mid-frame or in HOLD, discard the partial frame or pending result; no result is emitted for it.

Structure
REQ-030 SHALL define the FSM state enum (ACCUM, HOLD) and the default width constants in the shared package popcount_pkg.
REQ-031 SHALL implement the saturating adder as one sub-module, sat_add (parameterised width, overflow flag out), instantiated twice.
REQ-032 SHALL be implemented as a single clocked process plus next-state combinational logic, with no latches.

Verification
REQ-033 SHALL verify a three-beat frame: counts 13, 1, 10 with i_Last on the third beat -> next cycle o_FrameValid=1, o_FrameOnes=24, o_FrameWords=3, o_Saturated=0.
REQ-034 SHALL verify a single beat with count 16 and i_Last=1 -> o_FrameOnes=16 and o_FrameWords=1 one cycle later.
REQ-035 SHALL verify backpressure: i_FrameReady held at 0 for 5 cycles with i_Valid=1 and count 15 -> outputs stable, o_Ready=0, no accumulation; then i_FrameReady=1 -> o_FrameValid=0 and o_Ready=1 on the next edge.
REQ-036 SHALL verify saturation with ACCWIDTH=8: 20 beats of count 16, last on the 20th -> o_FrameOnes=255, o_FrameWords=20, o_Saturated=1; the following frame starts from 0 with o_Saturated=0.
REQ-037 SHALL verify reset mid-frame: beats 7 and 9, then i_rst for 1 cycle, then a beat of 4 with i_Last=1 -> o_FrameOnes=4, o_FrameWords=1.
REQ-038 SHALL verify count clamping: a beat with i_Count=31 at DATAWIDTH=16 and i_Last=1 -> o_FrameOnes=16.
